// File: rtl/piso_framer_if.sv
// Word-in / bit-out bundle for piso_framer: upstream valid/ready word handshake and abort,
//   downstream serial bit with its CRC window and frame-end markers.
// Ports: in_valid/in_ready/in_data/in_last/abort (to framer), so/so_valid/crc_en/frame_end (from framer).
// master = word producer / bit consumer side, slave = the framer itself.
interface piso_framer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              abort;
  logic              so;
  logic              so_valid;
  logic              crc_en;
  logic              frame_end;

  modport master (
    output in_valid, in_data, in_last, abort,
    input  in_ready, so, so_valid, crc_en, frame_end
  );

  modport slave (
    input  in_valid, in_data, in_last, abort,
    output in_ready, so, so_valid, crc_en, frame_end
  );
endinterface

// File: rtl/piso_framer.sv
// Parallel-to-serial framer: shifts DATA_W-bit words out one bit per clock, marks a CRC window and frame end.
// Latency: word accepted at edge k puts bit i on so during cycle k+1+i; all serial outputs registered.
// Backpressure: in_ready (combinational) only in IDLE or on the last bit of a word, so frames stream gap-free.
// Ports: clk, rst (async, active-low); io.slave carries the word handshake, abort and the serial outputs.
module piso_framer #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 0,
  parameter int CRC_OFFSET = 8,
  parameter int CRC_LEN    = 10,
  parameter int IFG        = 2,
  parameter int FB_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  piso_framer_if.slave  io
);

  localparam int              BW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int              GW         = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [BW-1:0]   BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [BW-1:0]   BIT_PENULT = BW'(DATA_W - 2);
  localparam logic [GW-1:0]   GAP_LAST   = GW'((IFG > 0) ? IFG - 1 : 0);
  localparam logic [63:0]     WIN_LO     = 64'(CRC_OFFSET);
  localparam logic [63:0]     WIN_HI     = WIN_LO + 64'(CRC_LEN);
  localparam bit              IFG_ZERO   = (IFG == 0);
  localparam bit              MSB        = (MSB_FIRST != 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] sh_q;          // bits still to send, refilled with idle ones
  logic [BW-1:0]     bit_cnt_q;     // index within the word of the bit currently on so
  logic              last_q;        // word currently shifting closes its frame
  logic              frame_open_q;  // a frame is in progress, next word continues its bit index
  logic [GW-1:0]     gap_cnt_q;
  logic [FB_W-1:0]   frame_idx_q;   // frame bit index of the bit currently on so
  logic              so_q;
  logic              so_valid_q;
  logic              crc_en_q;
  logic              frame_end_q;

  logic              accept;
  logic              word_end;
  logic [FB_W-1:0]   idx_inc_d;
  logic [FB_W-1:0]   idx_start_d;
  logic              first_bit_d;
  logic              next_bit_d;
  logic [DATA_W-1:0] load_sh_d;
  logic [DATA_W-1:0] shift_sh_d;

  function automatic logic in_win(input logic [FB_W-1:0] idx);
    logic [63:0] v;
    v = 64'(idx);
    return (v >= WIN_LO) && (v < WIN_HI);
  endfunction

  assign word_end    = (state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST);

  // A last word only hands over to the next frame on its final bit when there is no gap to insert.
  assign io.in_ready = !io.abort &&
                       ((state_q == S_IDLE) || (word_end && (!last_q || IFG_ZERO)));
  assign accept      = io.in_valid && io.in_ready;

  assign idx_inc_d   = (&frame_idx_q) ? frame_idx_q : frame_idx_q + FB_W'(1);
  assign idx_start_d = frame_open_q ? idx_inc_d : '0;

  assign first_bit_d = MSB ? io.in_data[DATA_W-1] : io.in_data[0];
  assign load_sh_d   = MSB ? {io.in_data[DATA_W-2:0], 1'b1} : {1'b1, io.in_data[DATA_W-1:1]};
  assign next_bit_d  = MSB ? sh_q[DATA_W-1] : sh_q[0];
  assign shift_sh_d  = MSB ? {sh_q[DATA_W-2:0], 1'b1} : {1'b1, sh_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sh_q         <= '1;
      bit_cnt_q    <= '0;
      last_q       <= 1'b0;
      frame_open_q <= 1'b0;
      gap_cnt_q    <= '0;
      frame_idx_q  <= '0;
      so_q         <= 1'b1;
      so_valid_q   <= 1'b0;
      crc_en_q     <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      frame_end_q <= 1'b0;
      if (io.abort) begin
        // Abort wins over any offered word and always closes the frame.
        state_q      <= IFG_ZERO ? S_IDLE : S_GAP;
        gap_cnt_q    <= '0;
        sh_q         <= '1;
        bit_cnt_q    <= '0;
        last_q       <= 1'b0;
        frame_open_q <= 1'b0;
        so_q         <= 1'b1;
        so_valid_q   <= 1'b0;
        crc_en_q     <= 1'b0;
      end else if (accept) begin
        state_q      <= S_SHIFT;
        sh_q         <= load_sh_d;
        so_q         <= first_bit_d;
        so_valid_q   <= 1'b1;
        bit_cnt_q    <= '0;
        last_q       <= io.in_last;
        frame_open_q <= !io.in_last;
        frame_idx_q  <= idx_start_d;
        crc_en_q     <= in_win(idx_start_d);
      end else begin
        case (state_q)
          S_SHIFT: begin
            if (word_end) begin
              // No follow-on word: a non-last word is an underrun, the frame stays open
              // and frame_idx_q is held for the word that eventually resumes it.
              so_q       <= 1'b1;
              so_valid_q <= 1'b0;
              crc_en_q   <= 1'b0;
              sh_q       <= '1;
              bit_cnt_q  <= '0;
              gap_cnt_q  <= '0;
              state_q    <= (last_q && !IFG_ZERO) ? S_GAP : S_IDLE;
            end else begin
              so_q        <= next_bit_d;
              sh_q        <= shift_sh_d;
              bit_cnt_q   <= bit_cnt_q + BW'(1);
              frame_idx_q <= idx_inc_d;
              crc_en_q    <= in_win(idx_inc_d);
              frame_end_q <= last_q && (bit_cnt_q == BIT_PENULT);
            end
          end
          S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= S_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + GW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign io.so        = so_q;
  assign io.so_valid  = so_valid_q;
  assign io.crc_en    = crc_en_q;
  assign io.frame_end = frame_end_q;

endmodule

// File: tb/tb_piso_framer.sv
module tb_piso_framer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piso_framer_if #(.DATA_W(8)) if0 ();
  piso_framer_if #(.DATA_W(8)) if1 ();

  // u0: LSB-first, window 8..17, gap 2.  u1: MSB-first, window 2..4, no gap.
  piso_framer #(.DATA_W(8), .MSB_FIRST(0), .CRC_OFFSET(8), .CRC_LEN(10), .IFG(2), .FB_W(16))
    u0 (.clk(clk), .rst(rst), .io(if0));
  piso_framer #(.DATA_W(8), .MSB_FIRST(1), .CRC_OFFSET(2), .CRC_LEN(3), .IFG(0), .FB_W(16))
    u1 (.clk(clk), .rst(rst), .io(if1));

  logic [1:0]      drv_valid = '0;
  logic [1:0]      drv_last  = '0;
  logic [1:0]      drv_abort = '0;
  logic [1:0][7:0] drv_data  = '0;
  logic [1:0]      rdy;

  assign if0.in_valid = drv_valid[0];
  assign if0.in_last  = drv_last[0];
  assign if0.abort    = drv_abort[0];
  assign if0.in_data  = drv_data[0];
  assign if1.in_valid = drv_valid[1];
  assign if1.in_last  = drv_last[1];
  assign if1.abort    = drv_abort[1];
  assign if1.in_data  = drv_data[1];
  assign rdy          = {if1.in_ready, if0.in_ready};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected serial bits per instance: {so, crc_en, frame_end}.
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vectors are written in send order: bit 7 of each argument is the first bit on so.
  task automatic exp_word(input bit inst, input int n, input logic [7:0] bits,
                          input logic [7:0] crc, input logic [7:0] fe);
    for (int i = 0; i < n; i++) begin
      if (inst) q1.push_back({bits[7-i], crc[7-i], fe[7-i]});
      else      q0.push_back({bits[7-i], crc[7-i], fe[7-i]});
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input bit inst, input logic [7:0] d, input logic l, output int acc);
    acc = -1;
    drv_valid[inst] = 1'b1;
    drv_data[inst]  = d;
    drv_last[inst]  = l;
    #1;
    for (int t = 0; t < 50 && acc < 0; t++) begin
      if (rdy[inst]) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    drv_valid[inst] = 1'b0;
    if (acc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL u%0d send timeout: word %h never accepted", inst, d);
    end
  endtask

  task automatic mon(input bit inst, input logic so, input logic sv, input logic ce, input logic fe);
    logic [2:0] e;
    bit         empty;
    empty = inst ? (q1.size() == 0) : (q0.size() == 0);
    if (sv) begin
      if (empty) begin
        n_chk++;
        n_fail++;
        $display("FAIL u%0d unexpected bit: so=%0d crc_en=%0d frame_end=%0d, expected no bit (t=%0t)",
                 inst, so, ce, fe, $time);
      end else begin
        e = inst ? q1.pop_front() : q0.pop_front();
        check($sformatf("u%0d so", inst),        int'(so), int'(e[2]));
        check($sformatf("u%0d crc_en", inst),    int'(ce), int'(e[1]));
        check($sformatf("u%0d frame_end", inst), int'(fe), int'(e[0]));
      end
    end else begin
      check($sformatf("u%0d idle {so,crc_en,frame_end}", inst), int'({so, ce, fe}), 4);
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(1'b0, if0.so, if0.so_valid, if0.crc_en, if0.frame_end);
    mon(1'b1, if1.so, if1.so_valid, if1.crc_en, if1.frame_end);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;

    // Reset state
    wait_cyc(3);
    check("reset so",       int'(if0.so), 1);
    check("reset so_valid", int'(if0.so_valid), 0);
    check("reset crc_en",   int'(if0.crc_en), 0);
    check("reset fe",       int'(if0.frame_end), 0);
    rst = 1'b1;
    #1;
    check("u0 in_ready after reset", int'(rdy[0]), 1);
    check("u1 in_ready after reset", int'(rdy[1]), 1);
    wait_cyc(1);

    // Single word 0xA5, LSB first, last; gap of 2 then ready
    exp_word(1'b0, 8, 8'b1010_0101, 8'h00, 8'b0000_0001);
    send(1'b0, 8'hA5, 1'b1, a);            // now in cycle k+1
    wait_cyc(9);                            // cycle k+10
    check("A5 in_ready in gap", int'(rdy[0]), 0);
    wait_cyc(1);                            // cycle k+11
    check("A5 in_ready after gap", int'(rdy[0]), 1);

    // Two-word frame 0x0F, 0xF0, valid held: second word is all CRC window
    exp_word(1'b0, 8, 8'b1111_0000, 8'h00, 8'h00);
    exp_word(1'b0, 8, 8'b0000_1111, 8'hFF, 8'b0000_0001);
    send(1'b0, 8'h0F, 1'b0, a);
    check("2w in_ready mid word", int'(rdy[0]), 0);
    send(1'b0, 8'hF0, 1'b1, b);
    check("2w accept spacing", b - a, 8);
    wait_cyc(12);

    // Underrun then resume: frame index continues at 8
    exp_word(1'b0, 8, 8'b0011_1100, 8'h00, 8'h00);
    send(1'b0, 8'h3C, 1'b0, a);
    wait_cyc(8);                            // cycle k+9
    check("underrun so_valid", int'(if0.so_valid), 0);
    check("underrun so", int'(if0.so), 1);
    check("underrun in_ready", int'(rdy[0]), 1);
    wait_cyc(4);
    exp_word(1'b0, 8, 8'b0110_1001, 8'hFF, 8'b0000_0001);
    send(1'b0, 8'h96, 1'b1, a);
    wait_cyc(12);

    // Abort on bit 3 with a word offered in the same cycle
    exp_word(1'b0, 4, 8'b0101_0000, 8'h00, 8'h00);
    send(1'b0, 8'h5A, 1'b0, a);            // cycle k+1
    wait_cyc(3);                            // cycle k+4, bit 3 on so
    drv_abort[0] = 1'b1;
    drv_valid[0] = 1'b1;
    drv_data[0]  = 8'hFF;
    drv_last[0]  = 1'b1;
    #1;
    check("abort in_ready", int'(rdy[0]), 0);
    wait_cyc(1);                            // cycle k+5
    drv_abort[0] = 1'b0;
    drv_valid[0] = 1'b0;
    #1;
    check("abort so_valid", int'(if0.so_valid), 0);
    check("abort so", int'(if0.so), 1);
    check("abort crc_en", int'(if0.crc_en), 0);
    check("abort gap in_ready 1", int'(rdy[0]), 0);
    wait_cyc(1);                            // cycle k+6
    check("abort gap in_ready 2", int'(rdy[0]), 0);
    wait_cyc(1);                            // cycle k+7
    check("abort in_ready back", int'(rdy[0]), 1);

    // MSB first, no IFG: 0x81 alone, then two frames back to back
    exp_word(1'b1, 8, 8'b1000_0001, 8'b0011_1000, 8'b0000_0001);
    send(1'b1, 8'h81, 1'b1, a);
    wait_cyc(8);                            // cycle k+9
    check("u1 idle after frame", int'(if1.so_valid), 0);
    check("u1 in_ready no gap", int'(rdy[1]), 1);
    exp_word(1'b1, 8, 8'b1000_0001, 8'b0011_1000, 8'b0000_0001);
    exp_word(1'b1, 8, 8'b0011_1100, 8'b0011_1000, 8'b0000_0001);
    send(1'b1, 8'h81, 1'b1, a);
    send(1'b1, 8'h3C, 1'b1, b);
    check("u1 b2b spacing", b - a, 8);
    wait_cyc(10);

    // Async reset mid-word (after two bits), then a clean word
    exp_word(1'b0, 2, 8'b1100_0000, 8'h00, 8'h00);
    send(1'b0, 8'hC3, 1'b1, a);            // cycle k+1
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid reset so", int'(if0.so), 1);
    check("mid reset so_valid", int'(if0.so_valid), 0);
    wait_cyc(2);
    rst = 1'b1;
    #1;
    check("post reset in_ready", int'(rdy[0]), 1);
    check("post reset so_valid", int'(if0.so_valid), 0);
    exp_word(1'b0, 8, 8'b1000_0111, 8'h00, 8'b0000_0001);
    send(1'b0, 8'hE1, 1'b1, a);
    wait_cyc(12);

    check("u0 expected bits drained", q0.size(), 0);
    check("u1 expected bits drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
